// File: rtl/pm32_arb_pkg.sv
// Shared types, constants and round-robin helpers for the pm32 arbiter slice.
package pm32_pkg;

  localparam int unsigned PM32_W   = 32;
  localparam int unsigned PM32_LAT = 68;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

  // Returns {found, index}: rotate so the pointer sits at bit 0, take the lowest
  // set bit, then map that position back to a requester index.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0] rot;
    logic       found;
    logic [2:0] j;
    rot   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) rot[i] = req[3'((32'(ptr) + i) % n)];
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        j     = 3'(i);
      end
    end
    return {found, 3'((32'(ptr) + 32'(j)) % n)};
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int unsigned n);
    return 3'((32'(idx) + 1) % n);
  endfunction

endpackage

// File: rtl/pm32_arb_pm32.sv
// Signed 32x32 serial multiplier: alternating add/shift half-steps plus one
// result-store cycle; mc is read live on every add step.
module pm32
  import pm32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PM32_W-1:0]     mc,
  input  logic [PM32_W-1:0]     mp,
  output logic [2*PM32_W-1:0]   p,
  output logic                  done
);

  localparam logic [6:0] STEP_LAST = 7'(PM32_LAT - 4);

  logic signed [PM32_W:0]   a_q, a_d;
  logic [PM32_W-1:0]        q_q, q_d;
  logic [6:0]               cnt_q, cnt_d;
  logic                     run_q, run_d;
  logic                     done_q, done_d;
  logic [2*PM32_W-1:0]      p_q, p_d;
  logic signed [PM32_W:0]   mc_ext;

  assign mc_ext = {mc[PM32_W-1], mc};

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = done_q;
    p_d    = p_q;
    if (start) begin
      a_d    = '0;
      q_d    = mp;
      cnt_d  = '0;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      if (cnt_q == STEP_LAST) begin
        p_d    = {a_q[PM32_W-1:0], q_q};
        done_d = 1'b1;
        run_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 7'd1;
        if (!cnt_q[0]) begin
          // The multiplier MSB carries negative weight, so the last step subtracts.
          if (q_q[0]) a_d = (cnt_q[6:1] == 6'd31) ? a_q - mc_ext : a_q + mc_ext;
        end else begin
          {a_d, q_d} = {a_q[PM32_W], a_q, q_q[PM32_W-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      p_q    <= '0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
      p_q    <= p_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: rtl/pm32_arb.sv
// Round-robin arbiter/sequencer sharing one pm32 serial multiplier among N requesters.
module pm32_arb
  import pm32_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [32*N-1:0]       req_mc,
  input  logic [32*N-1:0]       req_mp,
  output logic [N-1:0]          rsp_valid,
  input  logic [N-1:0]          rsp_ready,
  output logic [63:0]           rsp_p,
  output logic                  busy,
  output logic [2:0]            owner
);

  state_t                 state_q, state_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             owner_q, owner_d;
  logic [PM32_W-1:0]      mc_q, mc_d, mp_q, mp_d;
  logic [2*PM32_W-1:0]    p_q, p_d;
  logic [N-1:0]           rsp_valid_q, rsp_valid_d;
  logic                   busy_q, busy_d;

  logic [3:0]             pick;
  logic                   grant_ok;
  logic [2:0]             win;
  logic [PM32_W-1:0]      sel_mc, sel_mp;
  logic                   mul_rst, mul_start, mul_done;
  logic [2*PM32_W-1:0]    mul_p;

  assign pick     = rr_pick(8'(req_valid), ptr_q, N);
  assign win      = pick[2:0];
  assign grant_ok = pick[3] && (state_q == IDLE);
  assign req_ready = grant_ok ? (N'(1) << win) : '0;

  always_comb begin
    sel_mc = '0;
    sel_mp = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (3'(i) == win) begin
        sel_mc = req_mc[32*i +: 32];
        sel_mp = req_mp[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          mc_d    = sel_mc;
          mp_d    = sel_mp;
          owner_d = win;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RUN;
      RUN: begin
        if (mul_done) begin
          p_d     = mul_p;
          state_d = RESP;
        end
      end
      RESP: begin
        if ((rsp_ready & rsp_valid_q) != '0) begin
          state_d = IDLE;
          ptr_d   = rr_next(owner_q, N);
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP) ? (N'(1) << owner_d) : '0;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      p_q         <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      p_q         <= p_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign mul_rst   = ~rst_n;
  assign mul_start = (state_q == ISSUE);

  pm32 u_pm32 (
    .clk   (clk),
    .rst   (mul_rst),
    .start (mul_start),
    .mc    (mc_q),
    .mp    (mp_q),
    .p     (mul_p),
    .done  (mul_done)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = p_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
